// File: rtl/tb_judge_pkg.sv
// Shared definitions for the tohost pass/fail judge: FSM state encoding,
// the tohost pass code and a terminal-state helper.
package tb_judge_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    SETTLE = 3'd2,
    D_PASS = 3'd3,
    D_FAIL = 3'd4,
    D_TMO  = 3'd5,
    D_HANG = 3'd6
  } judge_state_e;

  localparam logic [31:0] TOHOST_PASS = 32'h1;

  function automatic logic is_terminal(input judge_state_e s);
    return (s == D_PASS) || (s == D_FAIL) || (s == D_TMO) || (s == D_HANG);
  endfunction

endpackage

// File: rtl/tb_judge_timer.sv
// Clearable up-counter; tc is high during the cycle that completes `limit`
// counted cycles (i.e. count + 1 >= limit).
module tb_judge_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Widened by one bit so the +1 cannot wrap at the top of the range.
  assign tc = ({1'b0, count} + {{W{1'b0}}, 1'b1}) >= {1'b0, limit};

endmodule

// File: rtl/tb_pass_judge.sv
// Testbench pass/fail judge: watches tohost writes and decides pass, fail,
// timeout or (with TB_STALL_DETECT_EN defined) hang on an unchanging PC.
module tb_pass_judge
  import tb_judge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd2000000,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned PASS_WRITES    = 1,
  parameter int unsigned STALL_CYCLES   = 1024
) (
  input  logic        tb_clk,
  input  logic        tb_rst_n,
  input  logic        start,
  input  logic [31:0] pc_write_to_host_cnt,
  input  logic [31:0] pc_write_to_host_cycle,
  input  logic [31:0] cycle_count,
  input  logic        tohost_wr,
  input  logic [31:0] tohost_data,
  input  logic [31:0] core_pc,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        hang,
  output logic [30:0] fail_code,
  output logic [31:0] end_cycle,
  output logic [2:0]  state
);

  judge_state_e state_q, state_nx;
  logic [31:0]  last_data, last_data_nx, start_cycle;
  logic         thr_hit, tmo_hit, stall_hit, settle_tc;

  assign state   = state_q;
  assign thr_hit = pc_write_to_host_cnt >= PASS_WRITES;
  assign tmo_hit = (cycle_count - start_cycle) >= TIMEOUT_CYCLES;

  tb_judge_timer #(.W(32)) u_settle (
    .clk   (tb_clk),
    .rst_n (tb_rst_n),
    .clr   (state_q != SETTLE),
    .en    (state_q == SETTLE),
    .limit (SETTLE_CYCLES),
    .tc    (settle_tc)
  );

`ifdef TB_STALL_DETECT_EN
  logic [31:0] prev_pc;
  logic        pc_same, stall_tc;

  always_ff @(posedge tb_clk) begin
    if (!tb_rst_n) prev_pc <= '0;
    else           prev_pc <= core_pc;
  end

  assign pc_same = (core_pc == prev_pc);

  // Any PC change restarts the consecutive-unchanged count.
  tb_judge_timer #(.W(32)) u_stall (
    .clk   (tb_clk),
    .rst_n (tb_rst_n),
    .clr   ((state_q != RUN) || !pc_same),
    .en    (state_q == RUN),
    .limit (STALL_CYCLES),
    .tc    (stall_tc)
  );

  assign stall_hit = (state_q == RUN) && pc_same && stall_tc;
`else
  logic unused_stall;
  assign unused_stall = ^{core_pc, STALL_CYCLES};
  assign stall_hit    = 1'b0;
`endif

  always_comb begin
    last_data_nx = last_data;
    state_nx     = state_q;
    if (!is_terminal(state_q) && tohost_wr) last_data_nx = tohost_data;
    case (state_q)
      IDLE:    if (start) state_nx = RUN;
      RUN: begin
        if (thr_hit)        state_nx = SETTLE;
        else if (tmo_hit)   state_nx = D_TMO;
        else if (stall_hit) state_nx = D_HANG;
      end
      // The verdict uses last_data_nx so a write in the final cycle counts.
      SETTLE:  if (settle_tc) state_nx = (last_data_nx == TOHOST_PASS) ? D_PASS : D_FAIL;
      default: state_nx = state_q;
    endcase
  end

  always_ff @(posedge tb_clk) begin
    if (!tb_rst_n) begin
      state_q     <= IDLE;
      last_data   <= '0;
      start_cycle <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      end_cycle   <= '0;
`ifdef TB_STALL_DETECT_EN
      hang        <= 1'b0;
`endif
    end else begin
      state_q   <= state_nx;
      last_data <= last_data_nx;
      if (state_q == IDLE && start) start_cycle <= cycle_count;
      if (!is_terminal(state_q) && is_terminal(state_nx)) begin
        done      <= 1'b1;
        pass      <= (state_nx == D_PASS);
        fail      <= (state_nx == D_FAIL);
        timeout   <= (state_nx == D_TMO);
        fail_code <= (state_nx == D_FAIL) ? last_data_nx[31:1] : 31'd0;
        end_cycle <= (state_nx == D_PASS || state_nx == D_FAIL) ?
                     pc_write_to_host_cycle : cycle_count;
`ifdef TB_STALL_DETECT_EN
        hang      <= (state_nx == D_HANG);
`endif
      end
    end
  end

`ifndef TB_STALL_DETECT_EN
  assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_tb_pass_judge.sv
// Bench for tb_pass_judge: directed and randomized runs checked every cycle
// against a model built from cycle indices relative to the start cycle.
module tb_tb_pass_judge;

  localparam int TMO = 50;
  localparam int SET = 8;
  localparam int STL = 16;
  localparam int K_THR = 0, K_TMO = 1, K_HANG = 2;
`ifdef TB_STALL_DETECT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        tb_clk = 1'b0;
  logic        tb_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tohost_wr = 1'b0;
  logic [31:0] pc_write_to_host_cnt = '0;
  logic [31:0] pc_write_to_host_cycle = '0;
  logic [31:0] cycle_count = '0;
  logic [31:0] tohost_data = '0;
  logic [31:0] core_pc = '0;
  logic        done, pass, fail, timeout, hang;
  logic [30:0] fail_code;
  logic [31:0] end_cycle;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  logic        wr_a  [0:127];
  logic [31:0] dat_a [0:127];

  tb_pass_judge #(
    .TIMEOUT_CYCLES (TMO),
    .SETTLE_CYCLES  (SET),
    .PASS_WRITES    (1),
    .STALL_CYCLES   (STL)
  ) dut (
    .tb_clk                 (tb_clk),
    .tb_rst_n               (tb_rst_n),
    .start                  (start),
    .pc_write_to_host_cnt   (pc_write_to_host_cnt),
    .pc_write_to_host_cycle (pc_write_to_host_cycle),
    .cycle_count            (cycle_count),
    .tohost_wr              (tohost_wr),
    .tohost_data            (tohost_data),
    .core_pc                (core_pc),
    .done                   (done),
    .pass                   (pass),
    .fail                   (fail),
    .timeout                (timeout),
    .hang                   (hang),
    .fail_code              (fail_code),
    .end_cycle              (end_cycle),
    .state                  (state)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic do_reset();
    @(negedge tb_clk);
    tb_rst_n = 1'b0;
    start = 1'b0;
    tohost_wr = 1'b0;
    pc_write_to_host_cnt = '0;
    @(negedge tb_clk);
    tb_rst_n = 1'b1;
  endtask

  task automatic clear_writes();
    for (int j = 0; j < 128; j++) begin
      wr_a[j]  = 1'b0;
      dat_a[j] = '0;
    end
  endtask

  // Cycle i = i-th negedge after the scenario begins; start is driven in cycle 0.
  task automatic run_scenario(input string name, input logic [31:0] c0, input int t,
                              input bit stall, input int abort_at, input bit skip_reset,
                              input logic [31:0] pcyc_v);
    int e, k, kind, last;
    logic [31:0] exp_last, pc, eend;
    logic [2:0]  es;
    logic        ed, ep, ef, et, eh;
    logic [30:0] efc;
    logic [70:0] got, expv;

    e = TMO;
    kind = K_TMO;
    if (stall && STALL_ON && STL < e) begin
      e = STL;
      kind = K_HANG;
    end
    if (t <= e) begin
      e = t;
      kind = K_THR;
    end
    k = (kind == K_THR) ? e + SET : e;
    last = k + 4;
    exp_last = '0;
    for (int j = 1; j <= k; j++) if (wr_a[j]) exp_last = dat_a[j];

    if (!skip_reset) do_reset();
    pc = $urandom;
    for (int i = 0; i <= last; i++) begin
      @(negedge tb_clk);
      got = {state, done, pass, fail, timeout, hang, fail_code, end_cycle};
      if (abort_at != 0 && i == abort_at + 1) begin
        checks++;
        if (got !== 71'd0) begin
          errors++;
          $display("FAIL %s reset-mid-run i=%0d got st=%0d flags=%b%b%b%b%b code=%h end=%h, want all zero",
                   name, i, state, done, pass, fail, timeout, hang, fail_code, end_cycle);
        end
        tb_rst_n = 1'b1;
        start = 1'b0;
        tohost_wr = 1'b0;
        pc_write_to_host_cnt = '0;
        return;
      end

      es = 3'd0; ed = 0; ep = 0; ef = 0; et = 0; eh = 0; efc = '0; eend = '0;
      if (i == 0)                         es = 3'd0;
      else if (i <= e)                    es = 3'd1;
      else if (kind == K_THR && i <= k)   es = 3'd2;
      else begin
        ed = 1'b1;
        eend = (kind == K_THR) ? pcyc_v : c0 + 32'(e);
        if (kind == K_THR && exp_last == 32'h1) begin
          es = 3'd3; ep = 1'b1;
        end else if (kind == K_THR) begin
          es = 3'd4; ef = 1'b1; efc = exp_last[31:1];
        end else if (kind == K_TMO) begin
          es = 3'd5; et = 1'b1;
        end else begin
          es = 3'd6; eh = 1'b1;
        end
      end
      expv = {es, ed, ep, ef, et, eh, efc, eend};
      checks++;
      if (got !== expv) begin
        errors++;
        $display("FAIL %s i=%0d got st=%0d dpfth=%b%b%b%b%b code=%h end=%h, want st=%0d dpfth=%b%b%b%b%b code=%h end=%h",
                 name, i, state, done, pass, fail, timeout, hang, fail_code, end_cycle,
                 es, ed, ep, ef, et, eh, efc, eend);
      end

      start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cycle_count = c0 + 32'(i);
      pc_write_to_host_cnt = (i >= t) ? 32'($urandom_range(1, 3)) : 32'd0;
      pc_write_to_host_cycle = (i <= k) ? pcyc_v : $urandom;
      tohost_wr = wr_a[i];
      tohost_data = dat_a[i];
      if (!stall) pc = pc + 32'd4;
      core_pc = pc;
      if (abort_at != 0 && i == abort_at) tb_rst_n = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({state, done, pass, fail, timeout, hang, fail_code, end_cycle} !== 71'd0) begin
      errors++;
      $display("FAIL reset got st=%0d flags=%b%b%b%b%b code=%h end=%h, want all zero",
               state, done, pass, fail, timeout, hang, fail_code, end_cycle);
    end
  endtask

  task automatic test_pass();
    clear_writes();
    wr_a[20] = 1'b1; dat_a[20] = 32'h1;
    run_scenario("pass", 32'd80, 20, 1'b0, 0, 1'b0, 32'd100);
  endtask

  task automatic test_fail();
    clear_writes();
    wr_a[3] = 1'b1; dat_a[3] = 32'h0000_000B;
    run_scenario("fail_code5", 32'd1000, 4, 1'b0, 0, 1'b0, $urandom);
    clear_writes();
    run_scenario("no_write", 32'd7, 6, 1'b0, 0, 1'b0, $urandom);
  endtask

  task automatic test_timeout();
    clear_writes();
    run_scenario("timeout", $urandom, 1000, 1'b0, 0, 1'b0, $urandom);
    run_scenario("timeout_wrap", 32'hFFFF_FFF0, 1000, 1'b0, 0, 1'b0, $urandom);
  endtask

  task automatic test_tie_and_last_write();
    clear_writes();
    wr_a[10] = 1'b1; dat_a[10] = 32'h1;
    run_scenario("thr_tmo_tie", 32'd500, TMO, 1'b0, 0, 1'b0, $urandom);
    clear_writes();
    wr_a[5]  = 1'b1; dat_a[5]  = 32'h1;
    wr_a[20] = 1'b1; dat_a[20] = 32'h3;
    wr_a[21] = 1'b1; dat_a[21] = 32'h1;
    run_scenario("last_settle_write", 32'd40, 12, 1'b0, 0, 1'b0, $urandom);
  endtask

  task automatic test_stall();
    clear_writes();
    run_scenario("stall", $urandom, 1000, 1'b1, 0, 1'b0, $urandom);
  endtask

  task automatic test_reset_mid_settle();
    clear_writes();
    wr_a[3] = 1'b1; dat_a[3] = 32'h1;
    run_scenario("abort_settle", 32'd200, 5, 1'b0, 9, 1'b0, $urandom);
    clear_writes();
    run_scenario("restart_after_abort", 32'd900, 4, 1'b0, 0, 1'b1, $urandom);
    wr_a[2] = 1'b1; dat_a[2] = 32'h1;
    run_scenario("restart_pass", 32'd950, 7, 1'b0, 0, 1'b0, $urandom);
  endtask

  task automatic test_random();
    logic [31:0] c0;
    for (int n = 0; n < 24; n++) begin
      clear_writes();
      for (int j = 1; j < 128; j++) begin
        wr_a[j]  = ($urandom_range(0, 3) == 0);
        dat_a[j] = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
      end
      c0 = (n % 4 == 0) ? 32'hFFFF_FFC0 + 32'($urandom_range(0, 63)) : $urandom;
      run_scenario("random", c0, $urandom_range(1, 70), 1'b0, 0, 1'b0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_tie_and_last_write();
    test_stall();
    test_reset_mid_settle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
